// File: rtl/wb_stage.sv
// MEM/WB pipeline register with load extraction, write-back select and ID-stage bypass copy.
// Optional retired-instruction counter enabled by defining WB_INSTRET_EN.
module wb_stage #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned INSTRET_W = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            flush,
  input  logic            in_valid,
  input  logic [4:0]      in_rd,
  input  logic            in_we,
  input  logic [1:0]      in_wb_sel,
  input  logic [XLEN-1:0] in_alu_res,
  input  logic [XLEN-1:0] in_mem_rdata,
  input  logic [XLEN-1:0] in_pc4,
  input  logic [XLEN-1:0] in_imm,
  input  logic [2:0]      in_funct3,
  input  logic [1:0]      in_addr_lo,
`ifdef WB_INSTRET_EN
  output logic [INSTRET_W-1:0] instret,
`endif
  output logic [4:0]      wR,
  output logic            we,
  output logic [XLEN-1:0] wD,
  output logic            wb_valid,
  output logic [4:0]      fwd_rd,
  output logic            fwd_en,
  output logic [XLEN-1:0] fwd_data
);

  localparam int unsigned RD_W = 5;

  if (XLEN != 32 || INSTRET_W < 1) begin : g_bad_cfg
    $error("wb_stage: XLEN must be 32 and INSTRET_W at least 1");
  end

  typedef struct packed {
    logic            valid;
    logic [RD_W-1:0] rd;
    logic            we;
    logic [1:0]      wb_sel;
    logic [XLEN-1:0] alu_res;
    logic [XLEN-1:0] mem_rdata;
    logic [XLEN-1:0] pc4;
    logic [XLEN-1:0] imm;
    logic [2:0]      funct3;
    logic [1:0]      addr_lo;
  } wb_regs_t;

  wb_regs_t q;
  wb_regs_t d;

  always_comb begin
    d.valid     = in_valid;
    d.rd        = in_rd;
    d.we        = in_we;
    d.wb_sel    = in_wb_sel;
    d.alu_res   = in_alu_res;
    d.mem_rdata = in_mem_rdata;
    d.pc4       = in_pc4;
    d.imm       = in_imm;
    d.funct3    = in_funct3;
    d.addr_lo   = in_addr_lo;
  end

  // Flush only kills the slot; data fields are don't-care so they simply hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (flush) begin
      q.valid <= 1'b0;
    end else if (!stall) begin
      q <= d;
    end
  end

  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [XLEN-1:0] ld_res;

  // Byte/half extraction from the aligned word; addr_lo[0] is ignored for halves.
  always_comb begin
    ld_byte = 8'h00;
    ld_half = 16'h0000;
    ld_res  = q.mem_rdata;
    case (q.addr_lo)
      2'd0:    ld_byte = q.mem_rdata[7:0];
      2'd1:    ld_byte = q.mem_rdata[15:8];
      2'd2:    ld_byte = q.mem_rdata[23:16];
      default: ld_byte = q.mem_rdata[31:24];
    endcase
    ld_half = q.addr_lo[1] ? q.mem_rdata[31:16] : q.mem_rdata[15:0];
    case (q.funct3)
      3'b000:  ld_res = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      3'b100:  ld_res = {{(XLEN-8){1'b0}}, ld_byte};
      3'b001:  ld_res = {{(XLEN-16){ld_half[15]}}, ld_half};
      3'b101:  ld_res = {{(XLEN-16){1'b0}}, ld_half};
      default: ld_res = q.mem_rdata;
    endcase
  end

  always_comb begin
    wD = q.alu_res;
    case (q.wb_sel)
      2'b00:   wD = q.alu_res;
      2'b01:   wD = ld_res;
      2'b10:   wD = q.pc4;
      default: wD = q.imm;
    endcase
  end

  // x0 writes are dropped here so the bypass never forwards a bogus x0 value.
  assign we       = q.valid & q.we & (q.rd != RD_W'(0));
  assign wR       = q.rd;
  assign wb_valid = q.valid;
  assign fwd_rd   = wR;
  assign fwd_en   = we;
  assign fwd_data = wD;

`ifdef WB_INSTRET_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instret <= '0;
    end else if (q.valid && !stall) begin
      instret <= instret + INSTRET_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Directed self-checking bench for wb_stage: reset, ALU/load/PC4/LUI write-back, x0, stall and flush.
`timescale 1ns/1ps
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, flush;
  logic        in_valid;
  logic [4:0]  in_rd;
  logic        in_we;
  logic [1:0]  in_wb_sel;
  logic [31:0] in_alu_res, in_mem_rdata, in_pc4, in_imm;
  logic [2:0]  in_funct3;
  logic [1:0]  in_addr_lo;
  logic [4:0]  wR;
  logic        we;
  logic [31:0] wD;
  logic        wb_valid;
  logic [4:0]  fwd_rd;
  logic        fwd_en;
  logic [31:0] fwd_data;
`ifdef WB_INSTRET_EN
  logic [63:0] instret;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  wb_stage dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_rd(in_rd), .in_we(in_we), .in_wb_sel(in_wb_sel),
    .in_alu_res(in_alu_res), .in_mem_rdata(in_mem_rdata), .in_pc4(in_pc4),
    .in_imm(in_imm), .in_funct3(in_funct3), .in_addr_lo(in_addr_lo),
`ifdef WB_INSTRET_EN
    .instret(instret),
`endif
    .wR(wR), .we(we), .wD(wD), .wb_valid(wb_valid),
    .fwd_rd(fwd_rd), .fwd_en(fwd_en), .fwd_data(fwd_data)
  );

  task automatic drive(input logic v, input logic [4:0] rd, input logic w,
                       input logic [1:0] sel, input logic [31:0] alu,
                       input logic [31:0] rdata, input logic [31:0] pc4,
                       input logic [31:0] imm, input logic [2:0] f3,
                       input logic [1:0] alo);
    in_valid = v; in_rd = rd; in_we = w; in_wb_sel = sel; in_alu_res = alu;
    in_mem_rdata = rdata; in_pc4 = pc4; in_imm = imm; in_funct3 = f3; in_addr_lo = alo;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    drive(1'b0, 5'd0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 3'b000, 2'b00);
    #12;
    checks++;
    if (wb_valid !== 1'b0 || we !== 1'b0 || wR !== 5'd0 || wD !== 32'h0) begin
      errors++;
      $display("FAIL reset_init: valid=%b we=%b wR=%0d wD=%h, want 0/0/0/0", wb_valid, we, wR, wD);
    end
    @(negedge clk); rst_n = 1'b1;
    // valid LB into x3, then assert reset between edges
    drive(1'b1, 5'd3, 1'b1, 2'b01, 32'h0, 32'h80F1_7F82, 32'h0, 32'h0, 3'b000, 2'b00);
    step;
    checks++;
    if (we !== 1'b1 || wD !== 32'hFFFF_FF82) begin
      errors++;
      $display("FAIL reset_preload: we=%b wD=%h, want 1 ffffff82", we, wD);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (wb_valid !== 1'b0 || we !== 1'b0 || wD !== 32'h0) begin
      errors++;
      $display("FAIL reset_async: valid=%b we=%b wD=%h, want 0 0 00000000", wb_valid, we, wD);
    end
    drive(1'b0, 5'd0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 3'b000, 2'b00);
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_alu;
    drive(1'b1, 5'd5, 1'b1, 2'b00, 32'h1234_5678, 32'h0, 32'h0, 32'h0, 3'b010, 2'b00);
    step;
    checks++;
    if (wR !== 5'd5 || we !== 1'b1 || wD !== 32'h1234_5678 || wb_valid !== 1'b1) begin
      errors++;
      $display("FAIL alu_write: wR=%0d we=%b wD=%h valid=%b, want 5 1 12345678 1", wR, we, wD, wb_valid);
    end
    checks++;
    if (fwd_rd !== 5'd5 || fwd_en !== 1'b1 || fwd_data !== 32'h1234_5678) begin
      errors++;
      $display("FAIL alu_fwd: rd=%0d en=%b data=%h, want 5 1 12345678", fwd_rd, fwd_en, fwd_data);
    end
  endtask

  task automatic test_loads;
    logic [2:0]  f3  [6] = '{3'b000, 3'b100, 3'b000, 3'b001, 3'b101, 3'b010};
    logic [1:0]  alo [6] = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd2, 2'd0};
    logic [31:0] exp [6] = '{32'hFFFF_FF82, 32'h0000_0082, 32'h0000_007F,
                             32'hFFFF_80F1, 32'h0000_80F1, 32'h80F1_7F82};
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 5'd10, 1'b1, 2'b01, 32'hDEAD_BEEF, 32'h80F1_7F82, 32'h0, 32'h0, f3[i], alo[i]);
      step;
      checks++;
      if (wD !== exp[i] || we !== 1'b1) begin
        errors++;
        $display("FAIL load_%0d: f3=%b alo=%0d wD=%h we=%b, want %h 1", i, f3[i], alo[i], wD, we, exp[i]);
      end
    end
  endtask

  task automatic test_x0_and_pc4;
    drive(1'b1, 5'd0, 1'b1, 2'b11, 32'h0, 32'h0, 32'h0, 32'hABCD_E000, 3'b000, 2'b00);
    step;
    checks++;
    if (we !== 1'b0 || wb_valid !== 1'b1 || wD !== 32'hABCD_E000) begin
      errors++;
      $display("FAIL x0_suppress: we=%b valid=%b wD=%h, want 0 1 abcde000", we, wb_valid, wD);
    end
    drive(1'b1, 5'd1, 1'b1, 2'b10, 32'h0, 32'h0, 32'h0000_0104, 32'h0, 3'b000, 2'b00);
    step;
    checks++;
    if (wD !== 32'h0000_0104 || we !== 1'b1 || wR !== 5'd1) begin
      errors++;
      $display("FAIL pc4_write: wD=%h we=%b wR=%0d, want 00000104 1 1", wD, we, wR);
    end
  endtask

  task automatic test_stall_flush;
    drive(1'b1, 5'd7, 1'b1, 2'b00, 32'h0000_CAFE, 32'h0, 32'h0, 32'h0, 3'b000, 2'b00);
    step;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 5'(9 + i), 1'b1, 2'b00, 32'h1111_0000 + 32'(i), 32'h0, 32'h0, 32'h0, 3'b000, 2'b00);
      step;
      checks++;
      if (wR !== 5'd7 || wD !== 32'h0000_CAFE || we !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold_%0d: wR=%0d wD=%h we=%b, want 7 0000cafe 1", i, wR, wD, we);
      end
    end
    flush = 1'b1;
    step;
    checks++;
    if (wb_valid !== 1'b0 || we !== 1'b0 || fwd_en !== 1'b0) begin
      errors++;
      $display("FAIL flush_over_stall: valid=%b we=%b fwd_en=%b, want 0 0 0", wb_valid, we, fwd_en);
    end
    flush = 1'b0; stall = 1'b0;
    drive(1'b0, 5'd4, 1'b1, 2'b00, 32'h5, 32'h0, 32'h0, 32'h0, 3'b000, 2'b00);
    step;
    checks++;
    if (wb_valid !== 1'b0 || we !== 1'b0) begin
      errors++;
      $display("FAIL invalid_capture: valid=%b we=%b, want 0 0", wb_valid, we);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] vals [3] = '{32'h0000_0001, 32'hFFFF_FFFF, 32'h7FFF_0000};
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 5'(20 + i), 1'b1, 2'b00, vals[i], 32'h0, 32'h0, 32'h0, 3'b000, 2'b00);
      step;
      checks++;
      if (wR !== 5'(20 + i) || wD !== vals[i] || fwd_data !== vals[i] || we !== 1'b1) begin
        errors++;
        $display("FAIL b2b_%0d: wR=%0d wD=%h fwd=%h we=%b, want %0d %h", i, wR, wD, fwd_data, we, 20 + i, vals[i]);
      end
    end
  endtask

`ifdef WB_INSTRET_EN
  task automatic test_instret;
    @(negedge clk); rst_n = 1'b0;
    #2 rst_n = 1'b1;
    drive(1'b0, 5'd0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 3'b000, 2'b00);
    for (int i = 0; i < 11; i++) begin
      drive(1'b1, 5'(i + 1), 1'b1, 2'b00, 32'(i), 32'h0, 32'h0, 32'h0, 3'b000, 2'b00);
      flush = (i == 7);
      step;
      if (i == 4) begin
        stall = 1'b1;
        step; step;
        stall = 1'b0;
      end
    end
    flush = 1'b0;
    drive(1'b0, 5'd0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 3'b000, 2'b00);
    step; step;
    checks++;
    if (instret !== 64'd10) begin
      errors++;
      $display("FAIL instret_count: got %0d, want 10", instret);
    end
  endtask
`endif

  initial begin
    test_reset;
    test_alu;
    test_loads;
    test_x0_and_pc4;
    test_stall_flush;
    test_back_to_back;
`ifdef WB_INSTRET_EN
    test_instret;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- MEM/WB pipeline register and write-back select for the pipelined RV32I core.
- Sits directly upstream of the register file write port and drives its wR/we/wD inputs.
- Captures MEM-stage results under stall/flush control.
- Performs load byte/half extraction with sign/zero extension.
- Selects the write-back source and exports a forwarding copy for ID-stage bypass.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- INSTRET_W, 64, width of the retired-instruction counter; used only with the optional feature.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- stall  input  1  hold current WB contents
- flush  input  1  invalidate the WB slot at the next edge
- in_valid  input  1  MEM-stage instruction valid
- in_rd  input  5  destination register
- in_we  input  1  instruction writes rd
- in_wb_sel  input  2  00 ALU, 01 load, 10 PC+4, 11 immediate (LUI)
- in_alu_res  input  32  ALU result
- in_mem_rdata  input  32  raw aligned data-memory word
- in_pc4  input  32  PC+4
- in_imm  input  32  U-immediate
- in_funct3  input  3  load type
- in_addr_lo  input  2  effective address bits [1:0]
- wR  output  5  RF write address
- we  output  1  RF write enable
- wD  output  32  RF write data
- wb_valid  output  1  WB slot holds a valid instruction
- fwd_rd  output  5  bypass destination (equals wR)
- fwd_en  output  1  bypass usable (equals we)
- fwd_data  output  32  bypass data (equals wD)

Behaviour:
- Clock and reset: one clock, clk. Reset is rst_n, asynchronous and active-low.
- While rst_n=0:
  - all stage registers clear to 0;
  - wb_valid=0, we=0, wR=0, wD=0 (wb_sel reset value 00 selects ALU result = 0).
- Reset asserted mid-operation drops the in-flight instruction immediately, with no write.
- Register update at each posedge clk, first matching rule applies:
  1. flush=1: valid <= 0; data fields may update but are don't-care. flush has priority over stall.
  2. stall=1: all fields hold.
  3. Otherwise: capture all in_* fields, with valid <= in_valid.
- Latency: one cycle from MEM inputs to wR/we/wD. The RF commits at the following edge.
- we = valid & stored_we & (stored_rd != 0). Writes to x0 are suppressed here as well as in the RF.
- we stays asserted during a stall. Re-writing the same value is harmless and required, since RF sees a held stage.
- wD is combinational from the registered fields:
  - 00 → alu_res
  - 01 → load result
  - 10 → pc4
  - 11 → imm
- Load extraction uses the registered mem_rdata, funct3 and addr_lo:
  - LB (000): byte at addr_lo (0→[7:0], 1→[15:8], 2→[23:16], 3→[31:24]), sign-extended.
  - LBU (100): same byte, zero-extended.
  - LH (001): half at addr_lo[1] (0→[15:0], 1→[31:16]), sign-extended. addr_lo[0] is ignored; misalignment is trapped upstream.
  - LHU (101): same half, zero-extended.
  - LW (010) and all other encodings: full word.
- Forwarding:
  - RF read is asynchronous while RF write is synchronous, so an ID-stage read in the same cycle sees the old value.
  - fwd_* are exact copies of wR/we/wD for the hazard unit to bypass.
- wb_valid = registered valid.

Optional Feature:
- Macro: WB_INSTRET_EN
- When defined:
  - Adds output instret [INSTRET_W-1:0], reset to 0.
  - Increments by 1 at each posedge where wb_valid=1 and stall=0 (one count per retired instruction, including x0-destination and non-writing instructions).
  - Wraps modulo 2^INSTRET_W.
  - flush does not decrement the count.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset: rst_n=0 mid-stream with a valid load in WB → we=0, wD=0, wb_valid=0 immediately, with no clock edge needed.
- ALU write: in_valid=1, rd=5, we=1, sel=00, alu=0x1234_5678 → next cycle wR=5, we=1, wD=0x1234_5678, fwd_data matches.
- Loads with rdata=0x80F1_7F82:
  - LB addr_lo=0 → 0xFFFF_FF82
  - LBU addr_lo=0 → 0x0000_0082
  - LB addr_lo=1 → 0x0000_007F
  - LH addr_lo=2 → 0xFFFF_80F1
  - LHU addr_lo=2 → 0x0000_80F1
  - LW → 0x80F1_7F82
- x0 suppression: rd=0, we=1, sel=11, imm=0xABCD_E000 → we=0 while wb_valid=1; sel=10, pc4=0x104, rd=1 → wD=0x104.
- Stall/flush:
  - Stall 3 cycles while new inputs change → wR/wD hold and we stays 1.
  - flush=1 with stall=1 → wb_valid=0 and we=0 after the edge.
- WB_INSTRET_EN: 10 valid instructions, 2 stalled cycles, 1 flushed slot → instret=10. Preload at 2^INSTRET_W−1, then one retire → instret=0.
